// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths and segment patterns for the seven-segment scan driver.
// Patterns are {g,f,e,d,c,b,a} with a = bit 0, logical 1 = segment lit.
package seg7_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;
    localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h71;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit code to active-high seven-segment pattern.
// Ports:
//   code_i  in  DIGIT_W  digit code 0-15
//   seg_o   out SEG_W    {g,f,e,d,c,b,a}; codes 10-15 blank unless DECODE_HEX != 0
import seg7_pkg::*;

module seg7_decode #(
    parameter int DECODE_HEX = 0
) (
    input  logic [DIGIT_W-1:0] code_i,
    output logic [SEG_W-1:0]   seg_o
);

    localparam bit HEX = DECODE_HEX != 0;

    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = HEX ? SEG_A : SEG_OFF;
            4'hB: seg_o = HEX ? SEG_B : SEG_OFF;
            4'hC: seg_o = HEX ? SEG_C : SEG_OFF;
            4'hD: seg_o = HEX ? SEG_D : SEG_OFF;
            4'hE: seg_o = HEX ? SEG_E : SEG_OFF;
            default: seg_o = HEX ? SEG_F : SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit seven-segment driver with frame-aligned data commit.
// Ports:
//   clk_i         in   1              rising-edge clock
//   reset_i       in   1              asynchronous active-high reset
//   digits_i      in   4*NUM_DIGITS   packed codes, digit 0 = digits_i[3:0], sampled on load_i
//   digit_en_i    in   NUM_DIGITS     per-digit enable, sampled on load_i (0 = slot dark)
//   load_i        in   1              capture strobe into shadow; committed at the next frame wrap
//   blank_i       in   1              live: forces all anodes inactive, scan keeps running
//   seg_o         out  7              registered segment drive {g,f,e,d,c,b,a}
//   an_o          out  NUM_DIGITS     registered one-hot anode drive
//   frame_done_o  out  1              one-cycle pulse when the scan wraps to digit 0
// Build option: define SEG7_LZB_EN for leading-zero blanking of active data.
import seg7_pkg::*;

module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int DECODE_HEX     = 0,
    parameter int ACTIVE_LOW_SEG = 0,
    parameter int ACTIVE_LOW_AN  = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]         digit_en_i,
    input  logic                          load_i,
    input  logic                          blank_i,
    output logic [SEG_W-1:0]              seg_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic                          frame_done_o
);

    localparam int DATA_W = DIGIT_W * NUM_DIGITS;
    localparam int IDX_W  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SEG_W-1:0]      SEG_POL = ACTIVE_LOW_SEG != 0 ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] AN_POL  = ACTIVE_LOW_AN != 0 ? '1 : '0;

    logic [DIV_W-1:0]      div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0] shadow_en_q, shadow_en_d;
    logic [DATA_W-1:0]     active_dig_q, active_dig_d;
    logic [NUM_DIGITS-1:0] active_en_q, active_en_d;
    logic                  pending_q, pending_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  tc, wrap;
    logic [NUM_DIGITS-1:0] lit_en;
    logic [DIGIT_W-1:0]    cur_code;
    logic                  cur_en;
    logic [NUM_DIGITS-1:0] cur_hot;
    logic [SEG_W-1:0]      cur_seg;

    // Scan counters and frame-aligned commit of shadow data
    always_comb begin
        tc           = div_q == DIV_W'(REFRESH_DIV - 1);
        wrap         = tc && idx_q == IDX_W'(NUM_DIGITS - 1);
        div_d        = tc ? '0 : div_q + DIV_W'(1);
        idx_d        = wrap ? '0 : tc ? idx_q + IDX_W'(1) : idx_q;
        shadow_dig_d = load_i ? digits_i : shadow_dig_q;
        shadow_en_d  = load_i ? digit_en_i : shadow_en_q;
        // A load landing on the wrap edge bypasses the shadow so it is not delayed a whole frame
        active_dig_d = wrap && load_i ? digits_i : wrap && pending_q ? shadow_dig_q : active_dig_q;
        active_en_d  = wrap && load_i ? digit_en_i : wrap && pending_q ? shadow_en_q : active_en_q;
        pending_d    = wrap ? 1'b0 : load_i ? 1'b1 : pending_q;
        frame_done_d = wrap;
    end

`ifdef SEG7_LZB_EN
    logic                  lz_run;
    logic [NUM_DIGITS-1:0] lz_mask;

    // Walk down from the top digit; a slot is blanked while every digit from it upward is zero
    always_comb begin
        lz_run  = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && active_dig_q[i*DIGIT_W +: DIGIT_W] == '0;
            lz_mask[i] = lz_run;
        end
    end

    assign lit_en = active_en_q & ~lz_mask;
`else
    assign lit_en = active_en_q;
`endif

    // Select the digit under the scan pointer
    always_comb begin
        cur_code = '0;
        cur_en   = 1'b0;
        cur_hot  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code   = active_dig_q[i*DIGIT_W +: DIGIT_W];
                cur_en     = lit_en[i];
                cur_hot[i] = 1'b1;
            end
        end
    end

    seg7_decode #(
        .DECODE_HEX(DECODE_HEX)
    ) u_decode (
        .code_i(cur_code),
        .seg_o (cur_seg)
    );

    // Polarity is applied only here so the decoder stays active-high
    always_comb begin
        seg_d = (cur_en ? cur_seg : SEG_OFF) ^ SEG_POL;
        an_d  = (cur_en && !blank_i ? cur_hot : '0) ^ AN_POL;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q        <= '0;
            idx_q        <= '0;
            shadow_dig_q <= '0;
            shadow_en_q  <= '0;
            active_dig_q <= '0;
            active_en_q  <= '0;
            pending_q    <= 1'b0;
            seg_q        <= SEG_OFF ^ SEG_POL;
            an_q         <= AN_POL;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_en_q  <= shadow_en_d;
            active_dig_q <= active_dig_d;
            active_en_q  <= active_en_d;
            pending_q    <= pending_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign an_o         = an_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan timing, commit, bypass, blanking, decode, polarity and LZB.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic        blank = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  en = '0;
    logic [6:0]  seg, seg_hex, seg_inv;
    logic [3:0]  an, an_hex, an_inv;
    logic        fd, fd_hex, fd_inv;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DECODE_HEX(0), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)) dut (
        .clk_i(clk), .reset_i(reset), .digits_i(digits), .digit_en_i(en), .load_i(load), .blank_i(blank),
        .seg_o(seg), .an_o(an), .frame_done_o(fd));

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DECODE_HEX(1), .ACTIVE_LOW_SEG(0), .ACTIVE_LOW_AN(0)) dut_hex (
        .clk_i(clk), .reset_i(reset), .digits_i(digits), .digit_en_i(en), .load_i(load), .blank_i(blank),
        .seg_o(seg_hex), .an_o(an_hex), .frame_done_o(fd_hex));

    seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DECODE_HEX(0), .ACTIVE_LOW_SEG(1), .ACTIVE_LOW_AN(1)) dut_inv (
        .clk_i(clk), .reset_i(reset), .digits_i(digits), .digit_en_i(en), .load_i(load), .blank_i(blank),
        .seg_o(seg_inv), .an_o(an_inv), .frame_done_o(fd_inv));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_len(input string tag, input int exp);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fd && n < 40);
        check(tag, n, exp);
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fd && n < 40);
        check(tag, {31'b0, fd}, 32'd1);
    endtask

    task automatic load_data(input logic [15:0] d, input logic [3:0] e);
        tick();
        digits = d;
        en     = e;
        load   = 1'b1;
        tick();
        load   = 1'b0;
    endtask

    // Starts on a frame_done sample; checks all 16 cycles of the following frame.
    // exp_seg/exp_hex pack {d3,d2,d1,d0}, 7 bits each.
    task automatic check_frame(input string tag, input logic [27:0] exp_seg, input logic [27:0] exp_hex,
                               input logic [3:0] mask);
        logic [6:0] es, eh, ies;
        logic [3:0] ea, iea;
        logic       ef;
        int         d;
        for (int k = 0; k < 16; k++) begin
            tick();
            d   = k / 4;
            es  = exp_seg[d*7 +: 7];
            eh  = exp_hex[d*7 +: 7];
            ea  = mask[d] ? 4'(1 << d) : 4'h0;
            ies = ~es;
            iea = ~ea;
            ef  = k == 15;
            check($sformatf("%s seg c%0d", tag, k), seg, es);
            check($sformatf("%s an c%0d", tag, k), an, ea);
            check($sformatf("%s hexseg c%0d", tag, k), seg_hex, eh);
            check($sformatf("%s hexan c%0d", tag, k), an_hex, ea);
            check($sformatf("%s invseg c%0d", tag, k), seg_inv, ies);
            check($sformatf("%s invan c%0d", tag, k), an_inv, iea);
            check($sformatf("%s fd c%0d", tag, k), fd, ef);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst seg", seg, 7'h00);
        check("rst an", an, 4'h0);
        check("rst fd", fd, 1'b0);
        check("rst hexseg", seg_hex, 7'h00);
        check("rst invseg", seg_inv, 7'h7F);
        check("rst invan", an_inv, 4'hF);
        reset = 1'b0;
        frame_len("first frame", 16);
        frame_len("frame period", 16);

        repeat (5) tick();
        digits = 16'h1234;
        en     = 4'hF;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check("old data an", an, 4'h0);
        wait_frame("wait 1234");
        check_frame("ld1234", {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}, 4'hF);

        repeat (15) tick();
        digits = 16'h5678;
        load   = 1'b1;
        tick();
        load   = 1'b0;
        check("bypass wrap fd", fd, 1'b1);
        check_frame("bypass", {7'h6D, 7'h7D, 7'h07, 7'h7F}, {7'h6D, 7'h7D, 7'h07, 7'h7F}, 4'hF);

        repeat (2) tick();
        digits = 16'h1111;
        load   = 1'b1;
        tick();
        digits = 16'h9090;
        tick();
        load   = 1'b0;
        tick();
        check("old mid seg", seg, 7'h07);
        wait_frame("wait 9090");
        check_frame("last wins", {7'h6F, 7'h3F, 7'h6F, 7'h3F}, {7'h6F, 7'h3F, 7'h6F, 7'h3F}, 4'hF);

        load_data(16'h1234, 4'b1010);
        wait_frame("wait en1010");
        check_frame("en1010", {7'h06, 7'h00, 7'h4F, 7'h00}, {7'h06, 7'h00, 7'h4F, 7'h00}, 4'b1010);
        repeat (5) tick();
        check("pre-blank an", an, 4'b0010);
        blank = 1'b1;
        tick();
        check("blank an", an, 4'h0);
        check("blank seg", seg, 7'h4F);
        check("blank invan", an_inv, 4'hF);
        frame_len("blank period", 10);
        check_frame("blanked", {7'h06, 7'h00, 7'h4F, 7'h00}, {7'h06, 7'h00, 7'h4F, 7'h00}, 4'h0);
        blank = 1'b0;

        load_data(16'hABCD, 4'hF);
        wait_frame("wait ABCD");
        check_frame("hexABCD", 28'h0, {7'h77, 7'h7C, 7'h39, 7'h5E}, 4'hF);
        load_data(16'hFE00, 4'hF);
        wait_frame("wait FE00");
        check_frame("hexFE", {7'h00, 7'h00, 7'h3F, 7'h3F}, {7'h71, 7'h79, 7'h3F, 7'h3F}, 4'hF);

        load_data(16'h0070, 4'hF);
        wait_frame("wait 0070");
`ifdef SEG7_LZB_EN
        check_frame("lzb0070", {7'h00, 7'h00, 7'h07, 7'h3F}, {7'h00, 7'h00, 7'h07, 7'h3F}, 4'b0011);
`else
        check_frame("nolzb0070", {7'h3F, 7'h3F, 7'h07, 7'h3F}, {7'h3F, 7'h3F, 7'h07, 7'h3F}, 4'hF);
`endif
        load_data(16'h0000, 4'hF);
        wait_frame("wait 0000");
`ifdef SEG7_LZB_EN
        check_frame("lzb0000", {7'h00, 7'h00, 7'h00, 7'h3F}, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001);
`else
        check_frame("nolzb0000", {7'h3F, 7'h3F, 7'h3F, 7'h3F}, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 4'hF);
`endif

        repeat (6) tick();
        reset = 1'b1;
        #2;
        check("async rst seg", seg, 7'h00);
        check("async rst an", an, 4'h0);
        check("async rst fd", fd, 1'b0);
        check("async rst invseg", seg_inv, 7'h7F);
        check("async rst invan", an_inv, 4'hF);
        tick();
        reset = 1'b0;
        frame_len("post-reset frame", 16);
        check("post-reset an", an, 4'h0);
        check("post-reset seg", seg, 7'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
